// File: rtl/weather_pkg.sv
// Shared weather-station types: mode encoding, compass codes and 7-segment glyphs.
// Glyphs are active-high {g,f,e,d,c,b,a}; the display driver inverts them for the pads.
package weather_pkg;

  typedef enum logic [2:0] {
    ST_RAIN     = 3'd0,
    ST_WIND_SPD = 3'd1,
    ST_WIND_DIR = 3'd2,
    ST_ELAPSED  = 3'd3,
    ST_CALIB    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } compass_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_N     = 7'h37;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_S     = 7'h6D;
  localparam logic [6:0] SEG_W     = 7'h3E;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // BCD nibble to glyph; non-decimal codes render blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, VAL_W clocks.
// Ports: start_i loads bin_i and (re)starts, abort_i drops a conversion in progress,
//        busy_o high while stepping, done_o one-clock pulse with bcd_o holding the result.
module bin2bcd_seq #(
  parameter int unsigned VAL_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [VAL_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      bcd_o
);

  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] sh_q, sh_d;
  logic [15:0]      bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Next-state: start wins over abort, abort wins over stepping.
  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    adj    = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      sh_d   = bin_i;
      bcd_d  = 16'd0;
      cnt_d  = CNT_W'(VAL_W);
      busy_d = 1'b1;
    end else if (abort_i) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      {bcd_d, sh_d} = {adj, sh_q} << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment driver for the weather station display modes.
// Ports: clk/rst (sync, active-high), tick_1kHz scan strobe, display_mode and the
//        measurement inputs in; active-low seg_n/dp_n/digit_n and busy out.
module display_scan_ctrl
  import weather_pkg::*;
#(
  parameter int unsigned VAL_W    = 14,
  parameter int unsigned MAX_DISP = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1kHz,
  input  logic [2:0]       display_mode,
  input  logic [VAL_W-1:0] rain_tenths,
  input  logic [VAL_W-1:0] wind_kmh,
  input  logic [2:0]       wind_dir,
  input  logic [VAL_W-1:0] elapsed_min,
  output logic [6:0]       seg_n,
  output logic             dp_n,
  output logic [3:0]       digit_n,
  output logic             busy
);

  logic [1:0]       scan_idx_q, scan_idx_d, disp_idx_q, disp_idx_d;
  logic             live_q, live_d, blank_q, blank_d;
  logic [2:0]       mode_q, mode_d;
  logic [15:0]      bcd_q, bcd_d, conv_bcd;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       digit_q, digit_d;
  logic             mode_chg, conv_go, conv_busy, conv_done;
  logic [VAL_W-1:0] raw, operand;
  logic [6:0]       glyph, let1, let0;
  logic             dp_on, nz3, nz32, nz321;
  logic [3:0]       nib;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_go),
    .abort_i (mode_chg),
    .bin_i   (operand),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Start logic, scan counter and blanking. A mode change always restarts;
  // a wrap start is dropped while a conversion is still running.
  always_comb begin
    mode_chg = (display_mode != mode_q);
    conv_go  = mode_chg | (tick_1kHz & (scan_idx_q == 2'd3) & ~conv_busy);
    case (display_mode)
      ST_RAIN:     raw = rain_tenths;
      ST_WIND_SPD: raw = wind_kmh;
      ST_ELAPSED:  raw = elapsed_min;
      default:     raw = '0;
    endcase
    operand = (raw > VAL_W'(MAX_DISP)) ? VAL_W'(MAX_DISP) : raw;

    scan_idx_d = tick_1kHz ? scan_idx_q + 2'd1 : scan_idx_q;
    // The tick shows the digit the counter pointed at, so digit 0 lights first.
    disp_idx_d = tick_1kHz ? scan_idx_q : disp_idx_q;
    live_d     = live_q | tick_1kHz;
    mode_d     = conv_go ? display_mode : mode_q;
    blank_d    = blank_q;
    bcd_d      = bcd_q;
    if (mode_chg) begin
      blank_d = 1'b1;
    end else if (conv_done) begin
      blank_d = 1'b0;
      bcd_d   = conv_bcd;
    end
  end

  // Glyph mux for the digit being shown, from next-state values.
  always_comb begin
    nz3   = (bcd_d[15:12] != 4'd0);
    nz32  = nz3 | (bcd_d[11:8] != 4'd0);
    nz321 = nz32 | (bcd_d[7:4] != 4'd0);
    case (disp_idx_d)
      2'd0:    nib = bcd_d[3:0];
      2'd1:    nib = bcd_d[7:4];
      2'd2:    nib = bcd_d[11:8];
      default: nib = bcd_d[15:12];
    endcase
    case (compass_t'(wind_dir))
      DIR_N:   {let1, let0} = {SEG_BLANK, SEG_N};
      DIR_NE:  {let1, let0} = {SEG_N, SEG_E};
      DIR_E:   {let1, let0} = {SEG_BLANK, SEG_E};
      DIR_SE:  {let1, let0} = {SEG_S, SEG_E};
      DIR_S:   {let1, let0} = {SEG_BLANK, SEG_S};
      DIR_SW:  {let1, let0} = {SEG_S, SEG_W};
      DIR_W:   {let1, let0} = {SEG_BLANK, SEG_W};
      default: {let1, let0} = {SEG_N, SEG_W};
    endcase
    glyph = SEG_BLANK;
    dp_on = 1'b0;
    case (mode_d)
      ST_RAIN: begin
        dp_on = (disp_idx_d == 2'd1);
        case (disp_idx_d)
          2'd3:    glyph = nz3  ? seg_digit(nib) : SEG_BLANK;
          2'd2:    glyph = nz32 ? seg_digit(nib) : SEG_BLANK;
          default: glyph = seg_digit(nib);
        endcase
      end
      ST_WIND_SPD, ST_ELAPSED: begin
        case (disp_idx_d)
          2'd3:    glyph = nz3   ? seg_digit(nib) : SEG_BLANK;
          2'd2:    glyph = nz32  ? seg_digit(nib) : SEG_BLANK;
          2'd1:    glyph = nz321 ? seg_digit(nib) : SEG_BLANK;
          default: glyph = seg_digit(nib);
        endcase
      end
      ST_WIND_DIR: begin
        case (disp_idx_d)
          2'd1:    glyph = let1;
          2'd0:    glyph = let0;
          default: glyph = SEG_BLANK;
        endcase
      end
      ST_CALIB: begin
        case (disp_idx_d)
          2'd3:    glyph = SEG_C;
          2'd2:    glyph = SEG_A;
          2'd1:    glyph = SEG_L;
          default: glyph = SEG_BLANK;
        endcase
      end
      default: glyph = SEG_DASH;
    endcase
    seg_d   = blank_d ? 7'h7F : ~glyph;
    dp_d    = ~(dp_on & ~blank_d);
    digit_d = live_d ? ~(4'b0001 << disp_idx_d) : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_q <= 2'd0;
      disp_idx_q <= 2'd0;
      live_q     <= 1'b0;
      blank_q    <= 1'b1;
      mode_q     <= 3'd0;
      bcd_q      <= 16'd0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      digit_q    <= 4'hF;
    end else begin
      scan_idx_q <= scan_idx_d;
      disp_idx_q <= disp_idx_d;
      live_q     <= live_d;
      blank_q    <= blank_d;
      mode_q     <= mode_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      digit_q    <= digit_d;
    end
  end

  assign seg_n   = seg_q;
  assign dp_n    = dp_q;
  assign digit_n = digit_q;
  assign busy    = conv_busy;

endmodule
